// File: rtl/seq_divider4_if.sv
// Start/done handshake and operand/result bus for seq_divider4.
// master = requester side, slave = divider side.
interface seq_divider4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider4.sv
// Multi-cycle unsigned non-restoring divider, one quotient bit per clock.
// Optional macro DIV_FASTPATH_EN: divisor==1 skips the iteration phase.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one shift + add/sub iteration per edge
// FIX   | remainder correction, result load (also divide-by-zero / fast path)
// DONE  | done pulse, then back to IDLE
module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider4_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef DIV_FASTPATH_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] d_reg, d_n;
  logic [WIDTH-1:0] q_reg, q_n;
  logic [WIDTH:0]   r_reg, r_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] quot_reg, quot_n;
  logic [WIDTH-1:0] rem_reg, rem_n;
  logic             busy_reg, busy_n;
  logic             done_reg, done_n;
  logic             dbz_reg, dbz_n;

  logic             sub_sel;
  logic [WIDTH:0]   r_shift, addend, r_step, r_fix;

  // Non-negative partial remainder subtracts (~D + 1), negative one adds D.
  always_comb begin
    sub_sel = ~r_reg[WIDTH];
    r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    addend  = sub_sel ? ~{1'b0, d_reg} : {1'b0, d_reg};
    r_step  = r_shift + addend + {{WIDTH{1'b0}}, sub_sel};
    r_fix   = r_reg[WIDTH] ? (r_reg + {1'b0, d_reg}) : r_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_reg    <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      cnt      <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      state    <= state_n;
      d_reg    <= d_n;
      q_reg    <= q_n;
      r_reg    <= r_n;
      cnt      <= cnt_n;
      quot_reg <= quot_n;
      rem_reg  <= rem_n;
      busy_reg <= busy_n;
      done_reg <= done_n;
      dbz_reg  <= dbz_n;
    end
  end

  always_comb begin
    state_n = state;
    d_n     = d_reg;
    q_n     = q_reg;
    r_n     = r_reg;
    cnt_n   = cnt;
    quot_n  = quot_reg;
    rem_n   = rem_reg;
    busy_n  = busy_reg;
    done_n  = done_reg;
    dbz_n   = dbz_reg;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          d_n    = bus.divisor;
          q_n    = bus.dividend;
          r_n    = '0;
          cnt_n  = '0;
          busy_n = 1'b1;
          dbz_n  = 1'b0;
          // Special divisors go straight to FIX so their results land one edge later.
          if (bus.divisor == '0 || (FAST_EN && bus.divisor == WIDTH'(1)))
            state_n = FIX;
          else
            state_n = CALC;
        end
      end
      CALC: begin
        r_n   = r_step;
        q_n   = {q_reg[WIDTH-2:0], ~r_step[WIDTH]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1))
          state_n = FIX;
      end
      FIX: begin
        done_n  = 1'b1;
        state_n = DONE;
        if (d_reg == '0) begin
          quot_n = '1;
          rem_n  = q_reg;
          dbz_n  = 1'b1;
        end else if (FAST_EN && d_reg == WIDTH'(1)) begin
          quot_n = q_reg;
          rem_n  = '0;
        end else begin
          r_n    = r_fix;
          quot_n = q_reg;
          rem_n  = r_fix[WIDTH-1:0];
        end
      end
      DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
